// File: rtl/ic_mem_responder_pkg.sv
// Shared definitions for the interconnect memory responder: FSM states and bus widths.
package ic_mem_responder_pkg;

    localparam int IC_WORD_W = 32;
    localparam int IC_STRB_W = 4;

    typedef enum logic [1:0] {
        IC_RSP_IDLE,
        IC_RSP_WAIT,
        IC_RSP_RSP
    } rsp_state_e;

endpackage

// File: rtl/ic_mem_array.sv
// Byte-lane word array with one synchronous port; read data is registered on enabled reads.
module ic_mem_array
  import ic_mem_responder_pkg::*;
#(
  parameter int    DEPTH_WORDS = 4096,
  parameter int    IDX_W       = $clog2(DEPTH_WORDS),
  parameter string INIT_FILE   = ""
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 wen,
  input  logic [IC_STRB_W-1:0] strb,
  input  logic [IDX_W-1:0]     idx,
  input  logic [IC_WORD_W-1:0] wdata,
  output logic [IC_WORD_W-1:0] rdata
);

  logic [IC_WORD_W-1:0] mem [DEPTH_WORDS];
  logic [IC_WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (wen) begin
        for (int unsigned i = 0; i < IC_STRB_W; i++) begin
          if (strb[i]) begin
            mem[idx][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata_q <= mem[idx];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ic_mem_responder.sv
// Responder end of the req/gnt/recv/ack memory protocol: decode, optional wait, held response.
module ic_mem_responder
    import ic_mem_responder_pkg::*;
#(
    parameter int    DEPTH_WORDS = 4096,
    parameter int    WAIT_CYCLES = 0,
    parameter bit    WRITABLE    = 1'b1,
    parameter string INIT_FILE   = ""
) (
    input  logic                 g_clk,
    input  logic                 g_reset,
    input  logic                 mem_req,
    input  logic                 mem_wen,
    input  logic [IC_STRB_W-1:0] mem_strb,
    input  logic [IC_WORD_W-1:0] mem_wdata,
    input  logic [31:0]          mem_addr,
    output logic                 mem_gnt,
    output logic                 mem_recv,
    input  logic                 mem_ack,
    output logic                 mem_error,
    output logic [IC_WORD_W-1:0] mem_rdata
);

    localparam int          IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);
    localparam logic [7:0]  WAIT_L  = 8'(WAIT_CYCLES);

    rsp_state_e           state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 rd_q, rd_d;
    logic [IDX_W-1:0]     idx;
    logic                 dec_err;
    logic                 gnt;
    logic                 accept;
    logic [IC_WORD_W-1:0] arr_rdata;
    logic                 unused_addr_hi;

    assign idx            = mem_addr[IDX_W+1:2];
    assign unused_addr_hi = ^mem_addr[31:IDX_W+2];
    assign dec_err        = (mem_addr[1:0] != 2'b00)
                          | (32'(idx) >= DEPTH_L)
                          | (mem_wen & ~WRITABLE);

    // Grant in RSP follows ack combinationally so a new request can ride the ack cycle.
    always_comb begin
        gnt = 1'b0;
        if (!g_reset) begin
            unique case (state_q)
                IC_RSP_IDLE: gnt = 1'b1;
                IC_RSP_RSP:  gnt = mem_ack;
                default:     gnt = 1'b0;
            endcase
        end
    end

    assign accept = mem_req & gnt;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rd_d    = rd_q;
        unique case (state_q)
            IC_RSP_IDLE: ;
            IC_RSP_WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    state_d = IC_RSP_RSP;
                end
            end
            IC_RSP_RSP: begin
                if (mem_ack) begin
                    state_d = IC_RSP_IDLE;
                    err_d   = 1'b0;
                    rd_d    = 1'b0;
                end
            end
            default: state_d = IC_RSP_IDLE;
        endcase
        // Acceptance can only occur in IDLE or in an RSP ack cycle, so it overrides both.
        if (accept) begin
            state_d = (WAIT_CYCLES > 0) ? IC_RSP_WAIT : IC_RSP_RSP;
            cnt_d   = WAIT_L;
            err_d   = dec_err;
            rd_d    = ~mem_wen & ~dec_err;
        end
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q <= IC_RSP_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
        end
    end

    ic_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W),
        .INIT_FILE   (INIT_FILE)
    ) u_array (
        .clk   (g_clk),
        .en    (accept & ~dec_err),
        .wen   (mem_wen),
        .strb  (mem_strb),
        .idx   (idx),
        .wdata (mem_wdata),
        .rdata (arr_rdata)
    );

    // The array read register only moves on an accepted read, so it doubles as the held response.
    assign mem_gnt   = gnt;
    assign mem_recv  = (state_q == IC_RSP_RSP);
    assign mem_error = mem_recv & err_q;
    assign mem_rdata = (mem_recv & rd_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_ic_mem_responder.sv
// Self-checking bench: RAM instance (no wait) and ROM instance (3 wait cycles) of ic_mem_responder.
module tb_ic_mem_responder;

    localparam int DEPTH = 100;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_req, a_wen, a_gnt, a_recv, a_ack, a_error;
    logic [3:0]  a_strb;
    logic [31:0] a_wdata, a_addr, a_rdata;
    logic        b_rst, b_req, b_wen, b_gnt, b_recv, b_ack, b_error;
    logic [3:0]  b_strb;
    logic [31:0] b_wdata, b_addr, b_rdata;

    ic_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (0),
        .WRITABLE    (1'b1),
        .INIT_FILE   ("")
    ) u_ram (
        .g_clk     (clk),
        .g_reset   (a_rst),
        .mem_req   (a_req),
        .mem_wen   (a_wen),
        .mem_strb  (a_strb),
        .mem_wdata (a_wdata),
        .mem_addr  (a_addr),
        .mem_gnt   (a_gnt),
        .mem_recv  (a_recv),
        .mem_ack   (a_ack),
        .mem_error (a_error),
        .mem_rdata (a_rdata)
    );

    ic_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (3),
        .WRITABLE    (1'b0),
        .INIT_FILE   ("")
    ) u_rom (
        .g_clk     (clk),
        .g_reset   (b_rst),
        .mem_req   (b_req),
        .mem_wen   (b_wen),
        .mem_strb  (b_strb),
        .mem_wdata (b_wdata),
        .mem_addr  (b_addr),
        .mem_gnt   (b_gnt),
        .mem_recv  (b_recv),
        .mem_ack   (b_ack),
        .mem_error (b_error),
        .mem_rdata (b_rdata)
    );

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] model [DEPTH];

    typedef struct {
        logic        wen;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic gnt_of(input bit sel);
        return sel ? b_gnt : a_gnt;
    endfunction

    function automatic logic recv_of(input bit sel);
        return sel ? b_recv : a_recv;
    endfunction

    function automatic logic err_of(input bit sel);
        return sel ? b_error : a_error;
    endfunction

    function automatic logic [31:0] rdata_of(input bit sel);
        return sel ? b_rdata : a_rdata;
    endfunction

    task automatic set_req(input bit sel, input logic req, input logic wen, input logic [3:0] strb,
                           input logic [31:0] wdata, input logic [31:0] addr);
        if (sel) begin
            b_req = req; b_wen = wen; b_strb = strb; b_wdata = wdata; b_addr = addr;
        end else begin
            a_req = req; a_wen = wen; a_strb = strb; a_wdata = wdata; a_addr = addr;
        end
    endtask

    task automatic set_ack(input bit sel, input logic v);
        if (sel) b_ack = v; else a_ack = v;
    endtask

    // One complete access: request, wait for grant, count cycles to recv, optionally stall ack.
    task automatic xfer(input bit sel, input logic wen, input logic [3:0] strb, input logic [31:0] wdata,
                        input logic [31:0] addr, input int ack_dly,
                        output logic [31:0] rdata, output logic err, output int lat);
        int budget;
        @(negedge clk);
        set_ack(sel, 1'b0);
        set_req(sel, 1'b1, wen, strb, wdata, addr);
        budget = 0;
        while (!gnt_of(sel) && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 50) timeout("gnt_wait");
        @(posedge clk);
        #1;
        set_req(sel, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!recv_of(sel) && lat < 50);
        if (lat >= 50) timeout("recv_wait");
        rdata = rdata_of(sel);
        err   = err_of(sel);
        repeat (ack_dly) @(negedge clk);
        if (ack_dly > 0) begin
            chk("hold_rdata", rdata_of(sel), rdata);
            chkb("hold_error", err_of(sel), err);
        end
        set_ack(sel, 1'b1);
        @(posedge clk);
        #1;
        set_ack(sel, 1'b0);
    endtask

    function automatic vec_t mk(input logic wen, input logic [3:0] strb, input logic [31:0] wdata,
                                input logic [31:0] addr, input logic [31:0] er, input logic ee);
        vec_t v;
        v.wen = wen; v.strb = strb; v.wdata = wdata; v.addr = addr;
        v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    initial begin
        logic [31:0] rd, addr, wd, exp_rd, word;
        logic        er, wen, exp_er;
        logic [3:0]  strb;
        int          lat, idx;

        a_rst = 1'b1; b_rst = 1'b1;
        a_ack = 1'b0; b_ack = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Reset state
        @(negedge clk);
        chkb("rst_a_gnt", a_gnt, 1'b0);
        chkb("rst_a_recv", a_recv, 1'b0);
        chkb("rst_a_error", a_error, 1'b0);
        chk("rst_a_rdata", a_rdata, 32'h0);
        chkb("rst_b_gnt", b_gnt, 1'b0);
        a_rst = 1'b0; b_rst = 1'b0;
        #1;
        chkb("idle_a_gnt", a_gnt, 1'b1);
        chkb("idle_b_gnt", b_gnt, 1'b1);

        // Directed vector table (RAM, no wait)
        vecs.push_back(mk(1, 4'hF, 32'hDEADBEEF, 32'h20, 32'h0, 0));
        vecs.push_back(mk(0, 4'h0, 32'h0, 32'h20, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 4'h5, 32'h11223344, 32'h20, 32'h0, 0));
        vecs.push_back(mk(0, 4'h0, 32'h0, 32'h20, 32'hDE22BE44, 0));
        vecs.push_back(mk(1, 4'h0, 32'hFFFFFFFF, 32'h20, 32'h0, 0));
        vecs.push_back(mk(0, 4'h0, 32'h0, 32'h20, 32'hDE22BE44, 0));
        vecs.push_back(mk(0, 4'h0, 32'h0, 32'h22, 32'h0, 1));
        vecs.push_back(mk(1, 4'hF, 32'h55555555, 32'h22, 32'h0, 1));
        vecs.push_back(mk(0, 4'h0, 32'h0, 32'h20, 32'hDE22BE44, 0));
        vecs.push_back(mk(0, 4'h0, 32'h0, DEPTH * 4, 32'h0, 1));
        vecs.push_back(mk(1, 4'hF, 32'hCAFEF00D, DEPTH * 4, 32'h0, 1));
        vecs.push_back(mk(0, 4'h0, 32'h0, 32'h10000020, 32'hDE22BE44, 0));
        vecs.push_back(mk(1, 4'hF, 32'h01020304, (DEPTH - 1) * 4, 32'h0, 0));
        vecs.push_back(mk(0, 4'h0, 32'h0, (DEPTH - 1) * 4, 32'h01020304, 0));
        foreach (vecs[i]) begin
            xfer(1'b0, vecs[i].wen, vecs[i].strb, vecs[i].wdata, vecs[i].addr, i % 3, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chkb($sformatf("vec%0d_error", i), er, vecs[i].exp_err);
            chk($sformatf("vec%0d_latency", i), lat, 32'd1);
        end

        // Randomized traffic against a word-array model
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            model[w] = wd;
            xfer(1'b0, 1'b1, 4'hF, wd, w * 4, 0, rd, er, lat);
            chkb("init_error", er, 1'b0);
        end
        for (int n = 0; n < 150; n++) begin
            wen  = 1'($urandom_range(0, 1));
            strb = 4'($urandom);
            wd   = $urandom;
            case ($urandom_range(0, 7))
                0:       addr = ($urandom & 32'hFFFFFE00) | ((100 + $urandom_range(0, 27)) * 4);
                1:       addr = ($urandom & 32'hFFFFFE00) | ($urandom_range(0, 15) * 4) | $urandom_range(1, 3);
                default: addr = ($urandom & 32'hFFFFFE00) | ($urandom_range(0, 15) * 4);
            endcase
            idx    = int'((addr / 4) % 128);
            exp_er = (addr % 4 != 0) || (idx >= DEPTH);
            exp_rd = 32'h0;
            if (!exp_er && wen) begin
                word = model[idx];
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) word = (word & ~(32'hFF << (8 * b))) | (wd & (32'hFF << (8 * b)));
                end
                model[idx] = word;
            end else if (!exp_er) begin
                exp_rd = model[idx];
            end
            xfer(1'b0, wen, strb, wd, addr, $urandom_range(0, 3), rd, er, lat);
            chk($sformatf("rnd%0d_rdata", n), rd, exp_rd);
            chkb($sformatf("rnd%0d_error", n), er, exp_er);
            chk($sformatf("rnd%0d_latency", n), lat, 32'd1);
        end

        // Back-to-back reads with req and ack held high
        @(negedge clk);
        a_ack = 1'b1;
        set_req(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (k < 3) a_addr = (k + 1) * 4;
            else a_req = 1'b0;
            @(negedge clk);
            chkb($sformatf("b2b%0d_recv", k), a_recv, 1'b1);
            chkb($sformatf("b2b%0d_gnt", k), a_gnt, 1'b1);
            chk($sformatf("b2b%0d_rdata", k), a_rdata, model[k]);
        end
        @(posedge clk);
        #1;
        a_ack = 1'b0;
        @(negedge clk);
        chkb("b2b_end_recv", a_recv, 1'b0);

        // Back-pressure with a queued request behind the held response
        set_req(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h20);
        @(posedge clk);
        #1;
        a_addr = 32'h4;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chkb("bp_recv", a_recv, 1'b1);
            chk("bp_rdata", a_rdata, model[8]);
            chkb("bp_error", a_error, 1'b0);
            chkb("bp_gnt", a_gnt, 1'b0);
        end
        a_ack = 1'b1;
        #1;
        chkb("bp_gnt_on_ack", a_gnt, 1'b1);
        @(posedge clk);
        #1;
        a_ack = 1'b0;
        a_req = 1'b0;
        @(negedge clk);
        chkb("bp_next_recv", a_recv, 1'b1);
        chk("bp_next_rdata", a_rdata, model[1]);
        a_ack = 1'b1;
        @(posedge clk);
        #1;
        a_ack = 1'b0;
        @(negedge clk);
        chkb("bp_done_recv", a_recv, 1'b0);

        // ROM instance: 3 wait cycles, writes rejected
        xfer(1'b1, 1'b1, 4'hF, 32'h12345678, 32'h0, 0, rd, er, lat);
        chkb("rom_wr_error", er, 1'b1);
        chk("rom_wr_rdata", rd, 32'h0);
        chk("rom_wr_latency", lat, 32'd4);
        xfer(1'b1, 1'b0, 4'h0, 32'h0, 32'h10, 1, rd, er, lat);
        chkb("rom_rd_error", er, 1'b0);
        chk("rom_rd_latency", lat, 32'd4);
        xfer(1'b1, 1'b0, 4'h0, 32'h0, 32'h11, 0, rd, er, lat);
        chkb("rom_mis_error", er, 1'b1);
        chk("rom_mis_rdata", rd, 32'h0);
        chk("rom_mis_latency", lat, 32'd4);

        // Reset during WAIT drops the pending response
        @(negedge clk);
        set_req(1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        b_req = 1'b0;
        @(negedge clk);
        chkb("wait_gnt", b_gnt, 1'b0);
        #1;
        b_rst = 1'b1;
        #1;
        chkb("rstw_recv", b_recv, 1'b0);
        chkb("rstw_gnt", b_gnt, 1'b0);
        chkb("rstw_error", b_error, 1'b0);
        @(negedge clk);
        b_rst = 1'b0;
        #1;
        chkb("rstw_idle_gnt", b_gnt, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chkb("rstw_no_recv", b_recv, 1'b0);
        end

        // Reset during an error response: recv and error fall without a clock edge
        set_req(1'b1, 1'b1, 1'b1, 4'hF, 32'hA5A5A5A5, 32'h0);
        @(posedge clk);
        #1;
        b_req = 1'b0;
        lat = 0;
        while (!b_recv && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 20) timeout("rstr_recv_wait");
        chkb("rstr_pre_error", b_error, 1'b1);
        #1;
        b_rst = 1'b1;
        #1;
        chkb("rstr_recv", b_recv, 1'b0);
        chkb("rstr_error", b_error, 1'b0);
        chkb("rstr_gnt", b_gnt, 1'b0);
        @(negedge clk);
        b_rst = 1'b0;
        #1;
        chkb("rstr_idle_gnt", b_gnt, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
